// File: rtl/sram_access_sequencer_pkg.sv
// Package: sram_pkg
// Shared definitions for the on-board async 512Kx8 SRAM sequencer:
//   - sequencer state encoding
//   - default array geometry (19-bit address, last address 19'h7FFFF)
//   - default WE pulse width and read wait, in clk cycles
//   - a small max helper used to size the wait counter
package sram_pkg;

  localparam int                 SRAM_AW        = 19;
  localparam logic [SRAM_AW-1:0] SRAM_LAST      = 19'h7FFFF;
  localparam int                 SRAM_WE_CYCLES = 1;
  localparam int                 SRAM_RD_WAIT   = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_SETUP = 3'd1,
    S_W_PULSE = 3'd2,
    S_W_HOLD  = 3'd3,
    S_TURN    = 3'd4,
    S_R_ADDR  = 3'd5,
    S_R_WAIT  = 3'd6,
    S_R_SEND  = 3'd7
  } seq_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_access_sequencer.sv
// Module: sram_access_sequencer
// Owns the async SRAM: runs a fill pass (writes fill_pattern to every byte
// 0..LAST_ADDR) or a dump pass (reads every byte and streams it out over a
// valid/ack byte interface towards the uart TX side).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_fill/cmd_dump/cmd_abort   1-cycle command pulses
//   fill_pattern                  byte written by a fill, sampled on acceptance
//   mem_adr, mem_dq_o, mem_dq_oe  SRAM address, write data, bus drive enable
//   mem_dq_i                      SRAM read data
//   ram_ce_n/ram_oe_n/ram_we_n    active-low SRAM strobes (registered)
//   tx_data, tx_valid, tx_ack     byte stream to the uart
//   busy, fill_done, dump_done    status; done flags are sticky
module sram_access_sequencer
  import sram_pkg::*;
#(
  parameter int            AW        = SRAM_AW,
  parameter logic [AW-1:0] LAST_ADDR = {AW{1'b1}},
  parameter int            WE_CYCLES = SRAM_WE_CYCLES,
  parameter int            RD_WAIT   = SRAM_RD_WAIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_fill,
  input  logic          cmd_dump,
  input  logic          cmd_abort,
  input  logic [7:0]    fill_pattern,
  output logic [AW-1:0] mem_adr,
  output logic [7:0]    mem_dq_o,
  output logic          mem_dq_oe,
  input  logic [7:0]    mem_dq_i,
  output logic          ram_ce_n,
  output logic          ram_oe_n,
  output logic          ram_we_n,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ack,
  output logic          busy,
  output logic          fill_done,
  output logic          dump_done
);

  localparam int              CNT_W   = $clog2(max2(WE_CYCLES, RD_WAIT) + 1);
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             abort_q;
  logic             abort_any;
  logic             at_last;
  logic             cnt_zero;
  logic             ce_n_d, oe_n_d, we_n_d, dq_oe_d;

  // A pending abort includes one arriving in the very cycle it is acted on.
  assign abort_any = abort_q | cmd_abort;
  assign at_last   = (mem_adr == LAST_ADDR);
  assign cnt_zero  = (cnt_q == '0);
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus strobe decode of the next state; the strobes are
  // registered from this decode so the SRAM never sees decode glitches and
  // bus drive / output enable always change on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (cmd_fill)      state_d = S_W_SETUP;
                 else if (cmd_dump) state_d = S_TURN;
      S_W_SETUP: state_d = S_W_PULSE;
      S_W_PULSE: if (cnt_zero) state_d = S_W_HOLD;
      S_W_HOLD:  state_d = (abort_any || at_last) ? S_IDLE : S_W_SETUP;
      S_TURN:    state_d = abort_any ? S_IDLE : S_R_ADDR;
      S_R_ADDR:  state_d = abort_any ? S_IDLE : S_R_WAIT;
      S_R_WAIT:  if (abort_any)     state_d = S_IDLE;
                 else if (cnt_zero) state_d = S_R_SEND;
      S_R_SEND:  if (tx_ack) state_d = (abort_any || at_last) ? S_IDLE : S_R_ADDR;
      default:   state_d = S_IDLE;
    endcase

    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    unique case (state_d)
      S_W_SETUP, S_W_HOLD: begin ce_n_d = 1'b0; dq_oe_d = 1'b1; end
      S_W_PULSE:           begin ce_n_d = 1'b0; dq_oe_d = 1'b1; we_n_d = 1'b0; end
      S_R_ADDR, S_R_WAIT, S_R_SEND: begin ce_n_d = 1'b0; oe_n_d = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      mem_adr   <= '0;
      mem_dq_o  <= '0;
      mem_dq_oe <= 1'b0;
      ram_ce_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      fill_done <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      ram_ce_n  <= ce_n_d;
      ram_oe_n  <= oe_n_d;
      ram_we_n  <= we_n_d;
      mem_dq_oe <= dq_oe_d;

      // Wait counter reloads on every state entry, counts down to zero.
      if (state_d != state_q)
        cnt_q <= (state_d == S_W_PULSE) ? WE_LOAD : RD_LOAD;
      else if (!cnt_zero)
        cnt_q <= cnt_q - 1'b1;

      // Abort is only meaningful during a pass and dies with it.
      if (state_d == S_IDLE)
        abort_q <= 1'b0;
      else if (cmd_abort && state_q != S_IDLE)
        abort_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (cmd_fill || cmd_dump) begin
            mem_adr   <= '0;
            fill_done <= 1'b0;
            dump_done <= 1'b0;
          end
          if (cmd_fill) mem_dq_o <= fill_pattern;
        end
        S_W_HOLD: begin
          if (!abort_any) begin
            if (at_last) fill_done <= 1'b1;
            else         mem_adr   <= mem_adr + 1'b1;
          end
        end
        S_R_WAIT: begin
          if (!abort_any && cnt_zero) begin
            tx_data  <= mem_dq_i;
            tx_valid <= 1'b1;
          end
        end
        S_R_SEND: begin
          if (tx_ack) begin
            tx_valid <= 1'b0;
            if (!abort_any) begin
              if (at_last) dump_done <= 1'b1;
              else         mem_adr   <= mem_adr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Testbench for sram_access_sequencer with a 16-byte behavioural SRAM model.
module tb_sram_access_sequencer;

  localparam int AW     = 19;
  localparam int WE_CYC = 2;
  localparam int RD_W   = 2;

  logic          clk;
  logic          rst;
  logic          cmd_fill, cmd_dump, cmd_abort;
  logic [7:0]    fill_pattern;
  logic [AW-1:0] mem_adr;
  logic [7:0]    mem_dq_o;
  logic          mem_dq_oe;
  logic [7:0]    mem_dq_i;
  logic          ram_ce_n, ram_oe_n, ram_we_n;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ack;
  logic          busy, fill_done, dump_done;

  sram_access_sequencer #(
    .AW(AW), .LAST_ADDR(19'd15), .WE_CYCLES(WE_CYC), .RD_WAIT(RD_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_fill(cmd_fill), .cmd_dump(cmd_dump), .cmd_abort(cmd_abort),
    .fill_pattern(fill_pattern),
    .mem_adr(mem_adr), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
    .mem_dq_i(mem_dq_i),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .busy(busy), .fill_done(fill_done), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // SRAM model: writes on the rising edge of we_n with the address and data
  // still held, reads combinationally while ce_n and oe_n are low.
  logic [7:0] mem [16];
  int   wr_cnt = 0, we_low = 0, we_bad = 0, bus_viol = 0, stab_bad = 0, tv_cnt = 0;
  logic we_prev = 1'b1, tv_prev = 1'b0;
  logic [7:0] td_prev = 8'h00;
  logic clr_req = 1'b0, preload_xor = 1'b0;

  assign mem_dq_i = (ram_ce_n === 1'b0 && ram_oe_n === 1'b0) ? mem[mem_adr[3:0]] : 8'hEE;

  always @(negedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 16; i++) mem[i] = preload_xor ? (8'(i) ^ 8'h3C) : 8'h00;
      wr_cnt = 0;
    end else if (ram_we_n === 1'b0) begin
      we_low = we_low + 1;
    end else begin
      if (we_prev === 1'b0 && ram_ce_n === 1'b0) begin
        if (we_low != WE_CYC || mem_dq_oe !== 1'b1 || mem_adr > 19'd15) we_bad = we_bad + 1;
        mem[mem_adr[3:0]] = mem_dq_o;
        wr_cnt = wr_cnt + 1;
      end
      we_low = 0;
    end
    we_prev = ram_we_n;
    if (ram_oe_n === 1'b0 && mem_dq_oe === 1'b1) bus_viol = bus_viol + 1;
    if (tx_valid === 1'b1 && tv_prev === 1'b1 && tx_data !== td_prev) stab_bad = stab_bad + 1;
    if (tx_valid === 1'b1 && tv_prev !== 1'b1) tv_cnt = tv_cnt + 1;
    tv_prev = tx_valid;
    td_prev = tx_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic x);
    preload_xor = x;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400 && busy !== 1'b0; k++) tick();
    chk(tag, busy, 0);
  endtask

  function automatic int mem_mismatch(input int lo, input int hi, input logic [7:0] v);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (mem[i] !== v) n++;
    return n;
  endfunction

  // Receives n bytes starting at address 'first'; dly < 0 means random ack delay.
  task automatic collect(input int first, input int n, input logic xr,
                         input logic [7:0] pat, input int dly);
    for (int i = first; i < first + n; i++) begin
      logic [7:0] e;
      int d;
      for (int k = 0; k < 50 && tx_valid !== 1'b1; k++) tick();
      chk("rx_valid", tx_valid, 1);
      if (tx_valid !== 1'b1) return;
      e = xr ? (8'(i) ^ 8'h3C) : pat;
      chk("rx_byte", tx_data, e);
      chk("rx_adr", mem_adr, i);
      d = (dly < 0) ? int'($urandom_range(0, 50)) : dly;
      repeat (d) tick();
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      chk("rx_valid_drop", tx_valid, 0);
    end
  endtask

  int tv0;

  initial begin
    rst = 1'b1; cmd_fill = 0; cmd_dump = 0; cmd_abort = 0; tx_ack = 0; fill_pattern = 8'h00;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ce", ram_ce_n, 1);
    chk("rst_oe", ram_oe_n, 1);
    chk("rst_we", ram_we_n, 1);
    chk("rst_dqoe", mem_dq_oe, 0);
    chk("rst_adr", mem_adr, 0);
    chk("rst_dq", mem_dq_o, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_fdone", fill_done, 0);
    chk("rst_ddone", dump_done, 0);
    rst = 1'b0;
    preload(1'b0);

    // Fill with A5, step through the first write access.
    fill_pattern = 8'hA5; cmd_fill = 1'b1;
    tick();
    cmd_fill = 1'b0; fill_pattern = 8'h00;
    chk("wsetup_busy", busy, 1);
    chk("wsetup_ce", ram_ce_n, 0);
    chk("wsetup_we", ram_we_n, 1);
    chk("wsetup_dqoe", mem_dq_oe, 1);
    chk("wsetup_dq", mem_dq_o, 8'hA5);
    chk("wsetup_adr", mem_adr, 0);
    tick(); chk("wpulse1_we", ram_we_n, 0);
    tick(); chk("wpulse2_we", ram_we_n, 0);
    tick(); chk("whold_we", ram_we_n, 1); chk("whold_adr", mem_adr, 0);
    tick(); chk("wsetup2_adr", mem_adr, 1);
    wait_idle("fill_idle");
    chk("fill_done", fill_done, 1);
    chk("fill_wrcnt", wr_cnt, 16);
    chk("fill_mem", mem_mismatch(0, 15, 8'hA5), 0);
    chk("fill_adr_end", mem_adr, 15);

    // Dump with a 3-cycle ack; a repeated cmd_dump while busy is ignored.
    tv0 = tv_cnt;
    cmd_dump = 1'b1;
    tick();
    chk("turn_busy", busy, 1);
    chk("turn_oe", ram_oe_n, 1);
    chk("turn_dqoe", mem_dq_oe, 0);
    chk("turn_fdone_clr", fill_done, 0);
    tick();
    cmd_dump = 1'b0;
    chk("raddr_oe", ram_oe_n, 0);
    chk("raddr_ce", ram_ce_n, 0);
    collect(0, 16, 1'b0, 8'hA5, 3);
    repeat (5) tick();
    chk("dump_done", dump_done, 1);
    chk("dump_busy", busy, 0);
    chk("dump_bytes", tv_cnt - tv0, 16);

    // Preloaded addr^3C, random ack delays.
    preload(1'b1);
    tv0 = tv_cnt;
    cmd_dump = 1'b1; tick(); cmd_dump = 1'b0;
    collect(0, 16, 1'b1, 8'h00, -1);
    wait_idle("rdump_idle");
    chk("rdump_done", dump_done, 1);
    chk("rdump_bytes", tv_cnt - tv0, 16);

    // Fill and dump together: fill only; dump during fill ignored.
    preload(1'b0);
    tv0 = tv_cnt;
    fill_pattern = 8'h5A; cmd_fill = 1'b1; cmd_dump = 1'b1;
    tick();
    cmd_fill = 1'b0; cmd_dump = 1'b0;
    chk("both_dqoe", mem_dq_oe, 1);
    chk("both_ddone_clr", dump_done, 0);
    repeat (6) tick();
    cmd_dump = 1'b1; tick(); cmd_dump = 1'b0;
    wait_idle("both_idle");
    chk("both_fdone", fill_done, 1);
    chk("both_ddone", dump_done, 0);
    chk("both_wrcnt", wr_cnt, 16);
    chk("both_mem", mem_mismatch(0, 15, 8'h5A), 0);
    chk("both_nobytes", tv_cnt - tv0, 0);

    // Abort during the write of address 7.
    preload(1'b0);
    fill_pattern = 8'h11; cmd_fill = 1'b1; tick(); cmd_fill = 1'b0;
    for (int k = 0; k < 200 && !(mem_adr == 19'd7 && ram_we_n === 1'b0); k++) tick();
    chk("abw_reach", ram_we_n, 0);
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
    wait_idle("abw_idle");
    chk("abw_fdone", fill_done, 0);
    chk("abw_wrcnt", wr_cnt, 8);
    chk("abw_mem_lo", mem_mismatch(0, 7, 8'h11), 0);
    chk("abw_mem_hi", mem_mismatch(8, 15, 8'h00), 0);
    chk("abw_adr", mem_adr, 7);

    // Abort in R_WAIT of address 4: bytes 0..3 only.
    preload(1'b1);
    tv0 = tv_cnt;
    cmd_dump = 1'b1; tick(); cmd_dump = 1'b0;
    collect(0, 4, 1'b1, 8'h00, 0);
    tick();
    chk("abr_adr", mem_adr, 4);
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
    chk("abr_busy", busy, 0);
    repeat (6) tick();
    chk("abr_txv", tx_valid, 0);
    chk("abr_bytes", tv_cnt - tv0, 4);
    chk("abr_ddone", dump_done, 0);

    // Abort in IDLE has no effect on the next pass.
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
    tick();
    fill_pattern = 8'hC3; cmd_fill = 1'b1; tick(); cmd_fill = 1'b0;
    wait_idle("abi_idle");
    chk("abi_fdone", fill_done, 1);
    chk("abi_wrcnt", wr_cnt, 16);

    chk("bus_conflict", bus_viol, 0);
    chk("we_width", we_bad, 0);
    chk("tx_stable", stab_bad, 0);

    // Reset while we_n is low.
    fill_pattern = 8'h77; cmd_fill = 1'b1; tick(); cmd_fill = 1'b0;
    for (int k = 0; k < 200 && !(mem_adr == 19'd3 && ram_we_n === 1'b0); k++) tick();
    chk("rstw_reach", ram_we_n, 0);
    rst = 1'b1; tick();
    chk("rstw_we", ram_we_n, 1);
    chk("rstw_ce", ram_ce_n, 1);
    chk("rstw_dqoe", mem_dq_oe, 0);
    chk("rstw_adr", mem_adr, 0);
    chk("rstw_dq", mem_dq_o, 0);
    chk("rstw_busy", busy, 0);
    rst = 1'b0; tick();

    // Reset while a byte is on offer.
    preload(1'b1);
    cmd_dump = 1'b1; tick(); cmd_dump = 1'b0;
    collect(0, 2, 1'b1, 8'h00, 0);
    for (int k = 0; k < 50 && tx_valid !== 1'b1; k++) tick();
    chk("rstr_reach", tx_valid, 1);
    rst = 1'b1; tick();
    chk("rstr_txv", tx_valid, 0);
    chk("rstr_txd", tx_data, 0);
    chk("rstr_oe", ram_oe_n, 1);
    chk("rstr_ce", ram_ce_n, 1);
    chk("rstr_adr", mem_adr, 0);
    chk("rstr_ddone", dump_done, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("rstr_after_txv", tx_valid, 0);
    chk("rstr_after_busy", busy, 0);
    chk("bus_conflict_end", bus_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
